// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy states, per-stage
// bundle widths and control-bit positions.
package pipe_pkg;

    // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b10,
        StFull  = 2'b11
    } state_e;

    localparam state_e ST_EMPTY = StEmpty;
    localparam state_e ST_BUSY  = StBusy;
    localparam state_e ST_FULL  = StFull;

    localparam int unsigned CTRL_W_DEFAULT      = 6;
    localparam int unsigned DATA_W_DEFAULT      = 160;
    localparam int unsigned STALL_CNT_W_DEFAULT = 16;

    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned ID_EX_DATA_W  = 160;
    localparam int unsigned EX_MEM_DATA_W = 107;
    localparam int unsigned MEM_WB_DATA_W = 69;

    localparam int unsigned CTL_JUMP     = 0;
    localparam int unsigned CTL_BRANCH   = 1;
    localparam int unsigned CTL_MEMREAD  = 2;
    localparam int unsigned CTL_MEMTOREG = 3;
    localparam int unsigned CTL_MEMWRITE = 4;
    localparam int unsigned CTL_REGWRITE = 5;

endpackage

// File: rtl/pipe_slot.sv
// One holding register of a pipeline stage: load-enabled, synchronously cleared.
module pipe_slot #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a two-entry skid buffer, flush and a saturating
// stall counter. in_ready_o depends only on registered state.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W      = CTRL_W_DEFAULT,
    parameter int unsigned DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned STALL_CNT_W = STALL_CNT_W_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [CTRL_W-1:0]      in_ctrl_i,
    input  logic [DATA_W-1:0]      in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [CTRL_W-1:0]      out_ctrl_o,
    output logic [DATA_W-1:0]      out_data_o,
    output logic [STALL_CNT_W-1:0] stall_count_o
);

    localparam int unsigned SlotW = CTRL_W + DATA_W;

    state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   accept, retire;
    logic                   main_load, skid_load;
    logic [SlotW-1:0]       in_slot, main_d, main_q, skid_q;

    assign in_slot     = {in_ctrl_i, in_data_i};
    assign in_ready_o  = (state_q != StFull);
    assign out_valid_o = (state_q != StEmpty);
    assign accept      = in_valid_i & in_ready_o;
    assign retire      = out_valid_o & out_ready_i;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_slot;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (accept && retire) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = StFull;
                end else if (retire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (retire) begin
                    main_d    = skid_q;
                    main_load = 1'b1;
                    state_d   = StBusy;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops held beats but leaves stale data in the slots.
        if (flush_i) begin
            state_d   = StEmpty;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    pipe_slot #(
        .Width (SlotW)
    ) u_main (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_slot #(
        .Width (SlotW)
    ) u_skid (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .load_i (skid_load),
        .d_i    (in_slot),
        .q_o    (skid_q)
    );

    // Bubbles must never carry MemWrite/RegWrite downstream.
    assign out_ctrl_o    = out_valid_o ? main_q[SlotW-1 -: CTRL_W] : '0;
    assign out_data_o    = main_q[DATA_W-1:0];
    assign stall_count_o = stall_q;

endmodule
